// File: rtl/shift_counter_gen.sv
// ---------------------------------------------------------------------------
// shift_counter_gen
//
// Parametrised Johnson / ring shift counter used as a phase or sequence
// generator. The mode, shift direction, parallel load and enable are selected
// at run time. The block also detects illegal states, with optional
// self-correction, decodes the current state index and produces a wrap pulse.
//
// Parameters
//   WIDTH        counter width in bits (>= 2)
//   SELF_CORRECT 1: an enabled step on an illegal state reloads the mode reset
//                value; 0: an illegal state is shifted like any other value
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-high
//   i_en         advance one step this cycle
//   i_mode       0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states)
//   i_dir        0 = shift toward LSB (new bit enters at MSB),
//                1 = shift toward MSB (new bit enters at LSB)
//   i_load       parallel load of i_load_val (overrides i_en)
//   i_load_val   value loaded when i_load = 1
//   o_count      registered counter state
//   o_state_idx  combinational decode of o_count, 0 when illegal
//   o_illegal    combinational, o_count is not legal for the current mode
//   o_wrap       registered one-cycle pulse, a legal enabled shift has just
//                entered state index 0
// ---------------------------------------------------------------------------
module shift_counter_gen #(
    parameter int unsigned WIDTH        = 4,
    parameter bit          SELF_CORRECT = 1'b1,
    localparam int unsigned IW          = $clog2(2 * WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic [IW-1:0]    o_state_idx,
    output logic             o_illegal,
    output logic             o_wrap
);

    // Decode a counter value for the given mode.
    // Returns {illegal, state_idx}; state_idx is forced to 0 when illegal.
    function automatic logic [IW:0] f_decode(input logic [WIDTH-1:0] v, input logic m);
        logic             ok;
        logic [IW-1:0]    idx;
        logic [WIDTH-1:0] pat;
        int unsigned      ones;
        ok   = 1'b0;
        idx  = '0;
        pat  = '0;
        ones = 0;
        if (!m) begin
            // pat holds k ones from the MSB. Its inverse is the trailing-ones
            // form with WIDTH-k ones, whose index is 2*WIDTH-(WIDTH-k).
            for (int k = 0; k <= int'(WIDTH); k++) begin
                for (int b = 0; b < int'(WIDTH); b++) begin
                    pat[b] = (b >= int'(WIDTH) - k);
                end
                if (v == pat) begin
                    ok  = 1'b1;
                    idx = IW'(k);
                end
                if ((k > 0) && (k < int'(WIDTH)) && (v == ~pat)) begin
                    ok  = 1'b1;
                    idx = IW'(int'(WIDTH) + k);
                end
            end
        end else begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                if (v[b]) begin
                    ones = ones + 1;
                    idx  = IW'(int'(WIDTH) - 1 - b);
                end
            end
            ok = (ones == 1);
        end
        if (!ok) begin
            idx = '0;
        end
        return {~ok, idx};
    endfunction

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic [WIDTH-1:0] w_count_d;
    logic             w_wrap_d;
    logic [WIDTH-1:0] w_rv;
    logic [WIDTH-1:0] w_shift;
    logic [IW:0]      w_dec;
    logic [IW:0]      w_shift_dec;

    // Mode reset value: Johnson all zeros, ring a single one in the MSB.
    assign w_rv = i_mode ? {1'b1, {(WIDTH - 1){1'b0}}} : '0;

    always_comb begin
        w_shift = r_count;
        unique case ({i_mode, i_dir})
            2'b00: w_shift = {~r_count[0], r_count[WIDTH-1:1]};
            2'b01: w_shift = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
            2'b10: w_shift = {r_count[0], r_count[WIDTH-1:1]};
            2'b11: w_shift = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
            default: w_shift = r_count;
        endcase
    end

    assign w_dec       = f_decode(r_count, i_mode);
    assign w_shift_dec = f_decode(w_shift, i_mode);

    // Priority: reset > load > enable. Wrap only follows a shift from a legal
    // state; correction steps and loads never raise it.
    always_comb begin
        w_count_d = r_count;
        w_wrap_d  = 1'b0;
        if (i_rst) begin
            w_count_d = w_rv;
        end else if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_en) begin
            if (w_dec[IW] && SELF_CORRECT) begin
                w_count_d = w_rv;
            end else begin
                w_count_d = w_shift;
                w_wrap_d  = ~w_dec[IW] & ~w_shift_dec[IW] & (w_shift_dec[IW-1:0] == '0);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_count <= w_count_d;
        r_wrap  <= w_wrap_d;
    end

    assign o_count     = r_count;
    assign o_wrap      = r_wrap;
    assign o_illegal   = w_dec[IW];
    assign o_state_idx = w_dec[IW-1:0];

endmodule
